decode_unit: RTL and testbench
==============================

Name: decode_unit

Overview:
- Instruction decode stage of the RISC-V integer pipeline, one stage upstream of the ALU.
- Accepts 32-bit instructions from fetch and decodes RV32I OP and OP-IMM forms (plus LUI) into cpu_core_pkg ALU opcodes.
- Reads operands from an internal 32-entry register file, with forwarding and interlock.
- Drives a registered opcode/operand/bubble bundle to the ALU and receives the ALU's registered result back for forwarding.

Parameters:
- XLEN, 32, datapath width; must match the `XLEN macro.
- NREGS, 32, register file depth; x0 is hardwired to zero.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- instr_valid_i  in  1  fetch presents an instruction.
- instr_i  in  32  instruction word.
- instr_ready_o  out  1  decode accepts instr_i this cycle.
- stall_i  in  1  pipeline stall; the same signal drives the ALU stall_i.
- alu_opcode_o  out  4  registered ALU opcode (cpu_core_pkg ALU_* values).
- rs0_data_o  out  XLEN  registered operand 0.
- rs1_data_o  out  XLEN  registered operand 1 (register value or immediate).
- du_bubble_o  out  1  registered bubble; 1 means no valid operation.
- rd_addr_o  out  5  registered destination register.
- alu_result_i  in  XLEN  ALU registered result.
- alu_bubble_i  in  1  ALU registered bubble.
- wb_en_i  in  1  writeback write enable.
- wb_addr_i  in  5  writeback register.
- wb_data_i  in  XLEN  writeback data.

Behaviour:
- Reset (synchronous, reset_i=1 at posedge):
  - alu_opcode_o=ALU_ADD, rs0/rs1_data_o=0, rd_addr_o=0, du_bubble_o=1.
  - Shadow EX destination ex_rd_q=0 and ex_valid_q=0.
  - Register file entries x1..x31 cleared to 0.
  - Reset overrides stall_i and wb_en_i.
- Decode, from opcode bits [6:0]:
  - 0110011 (OP): funct3/funct7[5] select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. rs1_data_o = reg[rs2].
  - 0010011 (OP-IMM): ADDI/SLTI/SLTIU/XORI/ORI/ANDI use the sign-extended imm[11:0]. SLLI/SRLI/SRAI use shamt=instr[24:20], and funct7 must be 0000000, or 0100000 for SRAI.
  - 0110111 (LUI): ALU_ADD, rs0=0, rs1={instr[31:12],12'b0}.
  - Any other opcode, or an illegal funct7: accepted, issues du_bubble_o=1, opcode ALU_ADD, operands 0, rd 0.
- Operand source priority, applied per source register:
  - Address 0 gives 0.
  - Otherwise, if ex_valid_q and ex_rd_q==rs, use alu_result_i (distance-2 forward).
  - Otherwise, if wb_en_i and wb_addr_i==rs, use wb_data_i (same-cycle write bypass).
  - Otherwise use the register file.
- Interlock (distance-1 RAW):
  - Condition: hazard = instr_valid_i & !du_bubble_o & rd_addr_o!=0 & the instruction uses rs equal to rd_addr_o.
  - Per source: OP uses rs1 and rs2, OP-IMM uses rs1, LUI uses none.
  - When hazard is set: instr_ready_o=0, and the next output register takes du_bubble_o=1.
  - The instruction is re-decoded the following cycle, when the forward path supplies the value.
  - Exactly one bubble is inserted per dependency.
- Handshake:
  - instr_ready_o = !stall_i & !hazard. This is combinational; it does not depend on instr_valid_i.
  - An instruction is accepted on a posedge with instr_valid_i & instr_ready_o.
  - When stall_i=0 and nothing is accepted (no valid, or hazard), the outputs load a bubble: du_bubble_o=1, rd=0.
- Stall (stall_i=1):
  - All output registers, ex_rd_q and ex_valid_q hold.
  - instr_ready_o=0.
  - Register file writes from writeback still occur.
- Shadow advance: when stall_i=0, ex_rd_q<=rd_addr_o and ex_valid_q<=!du_bubble_o & rd_addr_o!=0. This tracks the instruction entering the ALU result register.
- Register file: one write port, written at the posedge when wb_en_i & wb_addr_i!=0. Writes to x0 are ignored.
- Latency: an instruction accepted at edge N appears on the outputs after edge N. Its ALU result appears after edge N+1.

Test Plan:
1. Reset for 2 cycles, then release with no valid -> du_bubble_o=1, instr_ready_o=1, all outputs 0.
2. Writeback x5=0x10 and x6=0x3, then issue SUB x7,x5,x6 (0x406283B3) -> alu_opcode_o=ALU_SUB, rs0=0x10, rs1=0x3, rd=7, du_bubble_o=0.
3. ADDI x1,x0,-1 followed immediately by ADDI x2,x1,1 -> instr_ready_o=0 for one cycle with one bubble issued. Second instruction then issues with rs0=0xFFFFFFFF forwarded from alu_result_i.
4. wb_en_i writes x9=0xABCD in the same cycle that OR x10,x9,x0 is decoded -> rs0_data_o=0xABCD (bypass). A write to x0 leaves x0 reading as 0.
5. Hold stall_i=1 for 3 cycles with a valid instruction presented -> outputs unchanged, instr_ready_o=0. Instruction issues on the first unstalled edge.
6. Issue an illegal encoding (0x0000000B) and SRLI with funct7=0100001 -> both accepted, du_bubble_o=1. LUI x3,0x12345 -> ALU_ADD, rs0=0, rs1=0x12345000.

Source files
------------

// File: rtl/decode_unit.sv
// RV32I decode stage: decodes OP / OP-IMM / LUI into ALU opcodes, reads a 32-entry
// register file with distance-2 forwarding and write bypass, and interlocks distance-1 RAW.
`ifndef XLEN
`define XLEN 32
`endif

package cpu_core_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
endpackage

module decode_unit
  import cpu_core_pkg::*;
#(
  parameter int XLEN  = `XLEN,
  parameter int NREGS = 32
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  output logic            instr_ready_o,
  input  logic            stall_i,
  output logic [3:0]      alu_opcode_o,
  output logic [XLEN-1:0] rs0_data_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic            du_bubble_o,
  output logic [4:0]      rd_addr_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_bubble_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i
);

  // Handshake: instr_i is taken on a posedge where instr_valid_i & instr_ready_o;
  // instr_ready_o is combinational and independent of instr_valid_i.
  logic [XLEN-1:0] regs [NREGS];
  logic [4:0]      ex_rd_q;
  logic            ex_valid_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  logic            dec_ok, use_rs1, use_rs2, use_imm;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] imm;

  always_comb begin
    dec_ok  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_imm = 1'b0;
    dec_op  = ALU_ADD;
    imm     = '0;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_ok  = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        case (funct3)
          3'b000:  dec_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  dec_op = ALU_SLL;
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b101:  dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      7'b0010011: begin
        use_rs1 = 1'b1;
        use_imm = 1'b1;
        dec_ok  = 1'b1;
        imm     = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        case (funct3)
          3'b000: dec_op = ALU_ADD;
          3'b001: begin
            dec_op = ALU_SLL;
            imm    = XLEN'(rs2);
            dec_ok = (funct7 == 7'h00);
          end
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_op = ALU_SLTU;
          3'b100: dec_op = ALU_XOR;
          3'b101: begin
            dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
            imm    = XLEN'(rs2);
            dec_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      7'b0110111: begin
        use_imm = 1'b1;
        dec_ok  = 1'b1;
        imm     = XLEN'({instr_i[31:12], 12'b0});
      end
      default: ;
    endcase
    // Illegal encodings read nothing, so they never trigger an interlock.
    if (!dec_ok) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  logic hazard;
  assign hazard = instr_valid_i && !du_bubble_o && (rd_addr_o != 5'd0) &&
                  ((use_rs1 && rs1 == rd_addr_o) || (use_rs2 && rs2 == rd_addr_o));
  assign instr_ready_o = !stall_i && !hazard;

  // The ALU bubble qualifies the forward so a squashed result slot is never used.
  logic            fwd_ok;
  logic [XLEN-1:0] src0, src1;
  assign fwd_ok = ex_valid_q && !alu_bubble_i;

  always_comb begin
    src0 = regs[rs1];
    if (rs1 == 5'd0)                            src0 = '0;
    else if (fwd_ok && ex_rd_q == rs1)          src0 = alu_result_i;
    else if (wb_en_i && wb_addr_i == rs1)       src0 = wb_data_i;
    src1 = regs[rs2];
    if (rs2 == 5'd0)                            src1 = '0;
    else if (fwd_ok && ex_rd_q == rs2)          src1 = alu_result_i;
    else if (wb_en_i && wb_addr_i == rs2)       src1 = wb_data_i;
  end

  logic accept;
  assign accept = instr_valid_i && instr_ready_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      alu_opcode_o <= ALU_ADD;
      rs0_data_o   <= '0;
      rs1_data_o   <= '0;
      rd_addr_o    <= '0;
      du_bubble_o  <= 1'b1;
      ex_rd_q      <= '0;
      ex_valid_q   <= 1'b0;
    end else if (!stall_i) begin
      ex_rd_q    <= rd_addr_o;
      ex_valid_q <= !du_bubble_o && (rd_addr_o != 5'd0);
      if (accept && dec_ok) begin
        alu_opcode_o <= dec_op;
        rs0_data_o   <= use_rs1 ? src0 : '0;
        rs1_data_o   <= use_imm ? imm : src1;
        rd_addr_o    <= rd;
        du_bubble_o  <= 1'b0;
      end else begin
        alu_opcode_o <= ALU_ADD;
        rs0_data_o   <= '0;
        rs1_data_o   <= '0;
        rd_addr_o    <= '0;
        du_bubble_o  <= 1'b1;
      end
    end
  end

  // Writeback continues through stalls; x0 is never written so it always reads zero.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en_i && wb_addr_i != 5'd0) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: reset, OP/OP-IMM/LUI decode, interlock, forwarding,
// write bypass, stall hold and illegal-encoding bubbles.
module tb_decode_unit;
  import cpu_core_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        instr_ready_o;
  logic        stall_i;
  logic [3:0]  alu_opcode_o;
  logic [31:0] rs0_data_o, rs1_data_o;
  logic        du_bubble_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] alu_result_i;
  logic        alu_bubble_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;

  int checks = 0;
  int errors = 0;

  decode_unit dut (
    .clock_i(clock_i), .reset_i(reset_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .instr_ready_o(instr_ready_o), .stall_i(stall_i), .alu_opcode_o(alu_opcode_o),
    .rs0_data_o(rs0_data_o), .rs1_data_o(rs1_data_o), .du_bubble_o(du_bubble_o),
    .rd_addr_o(rd_addr_o), .alu_result_i(alu_result_i), .alu_bubble_i(alu_bubble_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  // Minimal registered ALU so forwarded results exist one cycle after issue.
  always @(posedge clock_i) begin
    if (reset_i) begin
      alu_result_i <= '0;
      alu_bubble_i <= 1'b1;
    end else if (!stall_i) begin
      alu_bubble_i <= du_bubble_o;
      case (alu_opcode_o)
        ALU_ADD: alu_result_i <= rs0_data_o + rs1_data_o;
        ALU_SUB: alu_result_i <= rs0_data_o - rs1_data_o;
        ALU_OR:  alu_result_i <= rs0_data_o | rs1_data_o;
        ALU_AND: alu_result_i <= rs0_data_o & rs1_data_o;
        ALU_XOR: alu_result_i <= rs0_data_o ^ rs1_data_o;
        default: alu_result_i <= '0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; stall_i = 1'b0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    tick(); tick();
    reset_i = 1'b0;
    tick();
    checks++; if (du_bubble_o !== 1'b1) begin errors++; $display("FAIL reset_bubble got %0b want 1", du_bubble_o); end
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", instr_ready_o); end
    checks++; if (alu_opcode_o !== ALU_ADD) begin errors++; $display("FAIL reset_op got %0d want %0d", alu_opcode_o, ALU_ADD); end
    checks++; if ({rs0_data_o, rs1_data_o} !== 64'd0) begin errors++; $display("FAIL reset_operands got %h %h want 0 0", rs0_data_o, rs1_data_o); end
    checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd_addr_o); end
  endtask

  task automatic test_op_sub();
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'h10; tick();
    wb_addr_i = 5'd6; wb_data_i = 32'h3; tick();
    wb_en_i = 1'b0;
    instr_valid_i = 1'b1; instr_i = 32'h406283B3;  // SUB x7,x5,x6
    tick();
    instr_valid_i = 1'b0;
    checks++; if (alu_opcode_o !== ALU_SUB) begin errors++; $display("FAIL sub_op got %0d want %0d", alu_opcode_o, ALU_SUB); end
    checks++; if (rs0_data_o !== 32'h10) begin errors++; $display("FAIL sub_rs0 got %h want 10", rs0_data_o); end
    checks++; if (rs1_data_o !== 32'h3) begin errors++; $display("FAIL sub_rs1 got %h want 3", rs1_data_o); end
    checks++; if (rd_addr_o !== 5'd7 || du_bubble_o !== 1'b0) begin errors++; $display("FAIL sub_rd got rd=%0d bubble=%0b want 7 0", rd_addr_o, du_bubble_o); end
    tick();
  endtask

  task automatic test_interlock();
    instr_valid_i = 1'b1; instr_i = 32'hFFF00093;  // ADDI x1,x0,-1
    tick();
    instr_i = 32'h00108113;                         // ADDI x2,x1,1
    #1;
    checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL hazard_ready got %0b want 0", instr_ready_o); end
    tick();
    checks++; if (du_bubble_o !== 1'b1 || rd_addr_o !== 5'd0) begin errors++; $display("FAIL hazard_bubble got bubble=%0b rd=%0d want 1 0", du_bubble_o, rd_addr_o); end
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL hazard_release got %0b want 1", instr_ready_o); end
    tick();
    instr_valid_i = 1'b0;
    checks++; if (rs0_data_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL fwd_rs0 got %h want ffffffff", rs0_data_o); end
    checks++; if (rs1_data_o !== 32'h1 || rd_addr_o !== 5'd2 || du_bubble_o !== 1'b0) begin errors++; $display("FAIL fwd_issue got rs1=%h rd=%0d bubble=%0b want 1 2 0", rs1_data_o, rd_addr_o, du_bubble_o); end
    tick();
  endtask

  task automatic test_bypass();
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'hABCD;
    instr_valid_i = 1'b1; instr_i = 32'h0004E533;   // OR x10,x9,x0
    tick();
    checks++; if (rs0_data_o !== 32'hABCD || rs1_data_o !== 32'h0) begin errors++; $display("FAIL bypass_operands got %h %h want abcd 0", rs0_data_o, rs1_data_o); end
    checks++; if (alu_opcode_o !== ALU_OR || rd_addr_o !== 5'd10) begin errors++; $display("FAIL bypass_op got op=%0d rd=%0d want %0d 10", alu_opcode_o, rd_addr_o, ALU_OR); end
    wb_addr_i = 5'd0; wb_data_i = 32'hDEAD;
    instr_i = 32'h009005B3;                         // ADD x11,x0,x9
    tick();
    wb_en_i = 1'b0; instr_valid_i = 1'b0;
    checks++; if (rs0_data_o !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h want 0", rs0_data_o); end
    checks++; if (rs1_data_o !== 32'hABCD) begin errors++; $display("FAIL x9_regfile got %h want abcd", rs1_data_o); end
    tick();
    instr_valid_i = 1'b1; instr_i = 32'h000005B3;   // ADD x11,x0,x0 after the x0 write
    tick();
    instr_valid_i = 1'b0;
    checks++; if (rs0_data_o !== 32'h0 || rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_after_write got %h %h want 0 0", rs0_data_o, rs1_data_o); end
    tick();
  endtask

  task automatic test_stall();
    instr_valid_i = 1'b1; instr_i = 32'h00548713;   // ADDI x14,x9,5
    tick();
    instr_i = 32'h0FF4F793;                         // ANDI x15,x9,0xFF
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready cycle %0d got %0b want 0", i, instr_ready_o); end
      tick();
      checks++; if (rd_addr_o !== 5'd14 || rs0_data_o !== 32'hABCD || rs1_data_o !== 32'h5 || du_bubble_o !== 1'b0)
        begin errors++; $display("FAIL stall_hold cycle %0d got rd=%0d rs0=%h rs1=%h bubble=%0b want 14 abcd 5 0", i, rd_addr_o, rs0_data_o, rs1_data_o, du_bubble_o); end
    end
    stall_i = 1'b0;
    #1;
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL unstall_ready got %0b want 1", instr_ready_o); end
    tick();
    instr_valid_i = 1'b0;
    checks++; if (alu_opcode_o !== ALU_AND || rs1_data_o !== 32'hFF || rd_addr_o !== 5'd15)
      begin errors++; $display("FAIL unstall_issue got op=%0d rs1=%h rd=%0d want %0d ff 15", alu_opcode_o, rs1_data_o, rd_addr_o, ALU_AND); end
    tick();
  endtask

  task automatic test_illegal_and_lui();
    instr_valid_i = 1'b1; instr_i = 32'h0000000B;
    #1;
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL illegal_ready got %0b want 1", instr_ready_o); end
    tick();
    checks++; if (du_bubble_o !== 1'b1 || rd_addr_o !== 5'd0 || alu_opcode_o !== ALU_ADD || rs0_data_o !== 32'h0)
      begin errors++; $display("FAIL illegal_opcode got bubble=%0b rd=%0d op=%0d rs0=%h want 1 0 0 0", du_bubble_o, rd_addr_o, alu_opcode_o, rs0_data_o); end
    instr_i = 32'h4234D813;                         // SRLI with funct7=0100001
    tick();
    checks++; if (du_bubble_o !== 1'b1 || rd_addr_o !== 5'd0 || rs1_data_o !== 32'h0)
      begin errors++; $display("FAIL illegal_funct7 got bubble=%0b rd=%0d rs1=%h want 1 0 0", du_bubble_o, rd_addr_o, rs1_data_o); end
    instr_i = 32'h4044D893;                         // SRAI x17,x9,4
    tick();
    checks++; if (alu_opcode_o !== ALU_SRA || rs0_data_o !== 32'hABCD || rs1_data_o !== 32'h4 || rd_addr_o !== 5'd17)
      begin errors++; $display("FAIL srai got op=%0d rs0=%h rs1=%h rd=%0d want %0d abcd 4 17", alu_opcode_o, rs0_data_o, rs1_data_o, rd_addr_o, ALU_SRA); end
    instr_i = 32'h123451B7;                         // LUI x3,0x12345
    tick();
    instr_valid_i = 1'b0;
    checks++; if (alu_opcode_o !== ALU_ADD || rs0_data_o !== 32'h0 || rs1_data_o !== 32'h12345000)
      begin errors++; $display("FAIL lui_operands got op=%0d rs0=%h rs1=%h want 0 0 12345000", alu_opcode_o, rs0_data_o, rs1_data_o); end
    checks++; if (rd_addr_o !== 5'd3 || du_bubble_o !== 1'b0) begin errors++; $display("FAIL lui_rd got rd=%0d bubble=%0b want 3 0", rd_addr_o, du_bubble_o); end
    tick();
    checks++; if (du_bubble_o !== 1'b1) begin errors++; $display("FAIL idle_bubble got %0b want 1", du_bubble_o); end
  endtask

  initial begin
    test_reset();
    test_op_sub();
    test_interlock();
    test_bypass();
    test_stall();
    test_illegal_and_lui();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
